reg_f_stack_ctrl: RTL and testbench

//  Parametrised register-file context stack with its own stack pointer: saves all NREGS registers as one frame on push, restores them on pop.

---
 rtl/reg_f_pkg.sv | 25 ++
 rtl/reg_f_stack_ram.sv | 31 +++
 rtl/reg_f_stack_ctrl.sv | 132 +++++++++++++
 tb/tb_reg_f_stack_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_f_pkg.sv
`default_nettype none
// =============================================================================
// Module : reg_f_pkg
// Desc   : Shared types for the register-file context stack (frame, FSM).
// Rev    : 1.0  initial release
// =============================================================================
package reg_f_pkg;

    localparam int RF_WIDTH = 8;
    localparam int RF_NREGS = 9;
    localparam int RF_DEPTH = 64;

    typedef logic [RF_NREGS*RF_WIDTH-1:0] frame_t;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        POP_RD = 1'b1
    } state_t;

    function automatic logic [RF_WIDTH-1:0] get_reg(input frame_t f, input int unsigned k);
        return f[k*RF_WIDTH +: RF_WIDTH];
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_f_stack_ram.sv
`default_nettype none
// =============================================================================
// Module : reg_f_stack_ram
// Desc   : Single-port frame RAM, synchronous write, registered 1-cycle read.
// Rev    : 1.0  initial release
// =============================================================================
module reg_f_stack_ram #(
    parameter int DW    = 72,
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic          i_re,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];

    // No reset on storage or read register so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (i_we)
            r_mem[i_addr] <= i_wdata;
        if (i_re)
            o_rdata <= r_mem[i_addr];
    end

endmodule
`default_nettype wire

// File: rtl/reg_f_stack_ctrl.sv
`default_nettype none
// =============================================================================
// Module : reg_f_stack_ctrl
// Desc   : Register-file context stack controller: push/pop whole frames.
// Rev    : 1.0  initial release
// =============================================================================
module reg_f_stack_ctrl
    import reg_f_pkg::*;
#(
    parameter  int WIDTH = RF_WIDTH,
    parameter  int NREGS = RF_NREGS,
    parameter  int DEPTH = RF_DEPTH,
    localparam int SP_W  = $clog2(DEPTH+1),
    localparam int FW    = NREGS*WIDTH,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic            clr_err,
    input  logic [FW-1:0]   regs_in,
    output logic            ready,
    output logic            pop_valid,
    output logic [FW-1:0]   regs_out,
    output logic [SP_W-1:0] sp,
    output logic            empty,
    output logic            full,
    output logic            ovf,
    output logic            unf
);

    state_t          r_state;
    logic            r_phase;
    logic [SP_W-1:0] r_sp;
    logic [AW-1:0]   r_rd_addr;
    logic            r_ready;
    logic            r_pop_valid;
    logic [FW-1:0]   r_regs_out;
    logic            r_ovf;
    logic            r_unf;

    logic            w_idle, w_full, w_empty;
    logic            w_push_req, w_pop_req, w_do_push, w_do_pop;
    logic            w_ovf_set, w_unf_set, w_ram_re;
    logic [AW-1:0]   w_ram_addr;
    logic [SP_W-1:0] w_sp_dec;
    logic [FW-1:0]   w_ram_rdata;

    assign w_idle     = (r_state == IDLE);
    assign w_full     = (r_sp == SP_W'(DEPTH));
    assign w_empty    = (r_sp == '0);
    assign w_push_req = w_idle & push & ~pop;
    assign w_pop_req  = w_idle & pop & ~push;
    assign w_do_push  = w_push_req & ~w_full;
    assign w_do_pop   = w_pop_req & ~w_empty;
    assign w_ovf_set  = w_push_req & w_full;
    assign w_unf_set  = w_pop_req & w_empty;
    assign w_sp_dec   = r_sp - SP_W'(1);

    // Pushes address the RAM at sp while idle; the pop's latched address is used in POP_RD.
    assign w_ram_re   = (r_state == POP_RD) & ~r_phase;
    assign w_ram_addr = w_idle ? r_sp[AW-1:0] : r_rd_addr;

    reg_f_stack_ram #(
        .DW    (FW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_do_push),
        .i_re    (w_ram_re),
        .i_addr  (w_ram_addr),
        .i_wdata (regs_in),
        .o_rdata (w_ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_phase     <= 1'b0;
            r_sp        <= '0;
            r_rd_addr   <= '0;
            r_ready     <= 1'b1;
            r_pop_valid <= 1'b0;
            r_regs_out  <= '0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
        end else begin
            r_pop_valid <= 1'b0;
            r_ovf       <= (r_ovf & ~clr_err) | w_ovf_set;
            r_unf       <= (r_unf & ~clr_err) | w_unf_set;
            case (r_state)
                IDLE: begin
                    if (w_do_push) begin
                        r_sp <= r_sp + SP_W'(1);
                    end else if (w_do_pop) begin
                        r_sp      <= w_sp_dec;
                        r_rd_addr <= w_sp_dec[AW-1:0];
                        r_phase   <= 1'b0;
                        r_ready   <= 1'b0;
                        r_state   <= POP_RD;
                    end
                end
                POP_RD: begin
                    // Phase 0 lets the RAM read register fill; phase 1 captures it.
                    if (!r_phase) begin
                        r_phase <= 1'b1;
                    end else begin
                        r_regs_out  <= w_ram_rdata;
                        r_pop_valid <= 1'b1;
                        r_ready     <= 1'b1;
                        r_phase     <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ready     = r_ready;
    assign pop_valid = r_pop_valid;
    assign regs_out  = r_regs_out;
    assign sp        = r_sp;
    assign empty     = w_empty;
    assign full      = w_full;
    assign ovf       = r_ovf;
    assign unf       = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_reg_f_stack_ctrl.sv
`default_nettype none
// =============================================================================
// Module : tb_reg_f_stack_ctrl
// Desc   : Self-checking bench: vector table, corner sequences, random vs model.
// Rev    : 1.0  initial release
// =============================================================================
module tb_reg_f_stack_ctrl;
    import reg_f_pkg::*;

    localparam int W    = 8;
    localparam int N    = 9;
    localparam int D    = 64;
    localparam int SP_W = $clog2(D+1);
    localparam int FW   = N*W;

    logic            clk = 1'b0;
    logic            rst, push, pop, clr_err;
    logic [FW-1:0]   regs_in;
    logic            ready, pop_valid, empty, full, ovf, unf;
    logic [FW-1:0]   regs_out;
    logic [SP_W-1:0] sp;

    int checks = 0;
    int errors = 0;

    // Reference model: a queue of frames plus a countdown to the pop result.
    logic [FW-1:0] m_stk[$];
    int            m_pend;
    logic [FW-1:0] m_pframe, m_out;
    bit            m_valid, m_ovf, m_unf;

    reg_f_stack_ctrl #(.WIDTH(W), .NREGS(N), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .clr_err(clr_err),
        .regs_in(regs_in), .ready(ready), .pop_valid(pop_valid),
        .regs_out(regs_out), .sp(sp), .empty(empty), .full(full),
        .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            pu, po, cl;
        logic [FW-1:0] d;
        int            e_sp;
        bit            e_rdy, e_v, e_ovf, e_unf;
        logic [FW-1:0] e_out;
    } vec_t;

    vec_t tbl[12];

    function automatic logic [FW-1:0] mkf(input int s);
        logic [FW-1:0] f;
        for (int k = 0; k < N; k++)
            f[k*W +: W] = 8'(s + k + 1);
        return f;
    endfunction

    task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_model();
        chk("sp", FW'(sp), FW'(m_stk.size()));
        chk("empty", FW'(empty), FW'(m_stk.size() == 0));
        chk("full", FW'(full), FW'(m_stk.size() == D));
        chk("ready", FW'(ready), FW'(m_pend == 0));
        chk("pop_valid", FW'(pop_valid), FW'(m_valid));
        chk("regs_out", regs_out, m_out);
        chk("ovf", FW'(ovf), FW'(m_ovf));
        chk("unf", FW'(unf), FW'(m_unf));
    endtask

    task automatic step(input bit pu, input bit po, input bit cl, input logic [FW-1:0] d);
        bit rdy, so, su;
        push = pu; pop = po; clr_err = cl; regs_in = d;
        @(posedge clk); #1;
        rdy = (m_pend == 0);
        so = 1'b0; su = 1'b0;
        m_valid = 1'b0;
        if (m_pend > 0) begin
            m_pend--;
            if (m_pend == 0) begin
                m_out   = m_pframe;
                m_valid = 1'b1;
            end
        end
        if (rdy) begin
            if (pu && !po) begin
                if (m_stk.size() == D) so = 1'b1;
                else m_stk.push_back(d);
            end else if (po && !pu) begin
                if (m_stk.size() == 0) su = 1'b1;
                else begin
                    m_pframe = m_stk.pop_back();
                    m_pend   = 2;
                end
            end
        end
        if (cl) begin m_ovf = 1'b0; m_unf = 1'b0; end
        m_ovf = m_ovf | so;
        m_unf = m_unf | su;
        push = 1'b0; pop = 1'b0; clr_err = 1'b0;
        check_model();
    endtask

    task automatic do_reset();
        rst = 1'b1; push = 1'b0; pop = 1'b0; clr_err = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        m_stk.delete();
        m_pend = 0; m_out = '0; m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
        check_model();
    endtask

    initial begin
        logic [FW-1:0] d1, d2, d3, rnd;
        int pp, po_pct;
        d1 = mkf(16); d2 = mkf(32); d3 = mkf(48);
        //          pu po cl  d   sp rdy v ovf unf out
        tbl[0]  = '{1, 0, 0, d1, 1, 1, 0, 0, 0, '0};
        tbl[1]  = '{1, 0, 0, d2, 2, 1, 0, 0, 0, '0};
        tbl[2]  = '{1, 1, 0, d3, 2, 1, 0, 0, 0, '0};
        tbl[3]  = '{0, 1, 0, '0, 1, 0, 0, 0, 0, '0};
        tbl[4]  = '{1, 0, 0, d3, 1, 0, 0, 0, 0, '0};
        tbl[5]  = '{0, 0, 0, '0, 1, 1, 1, 0, 0, d2};
        tbl[6]  = '{0, 1, 0, '0, 0, 0, 0, 0, 0, d2};
        tbl[7]  = '{0, 0, 0, '0, 0, 0, 0, 0, 0, d2};
        tbl[8]  = '{0, 0, 0, '0, 0, 1, 1, 0, 0, d1};
        tbl[9]  = '{0, 1, 0, '0, 0, 1, 0, 0, 1, d1};
        tbl[10] = '{0, 0, 1, '0, 0, 1, 0, 0, 0, d1};
        tbl[11] = '{0, 1, 1, '0, 0, 1, 0, 0, 1, d1};

        rst = 1'b1; push = 1'b0; pop = 1'b0; clr_err = 1'b0; regs_in = '0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Table vectors: push/pop, illegal push&pop, push during POP_RD, underflow, clr_err.
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].pu, tbl[i].po, tbl[i].cl, tbl[i].d);
            chk($sformatf("row%0d_sp", i), FW'(sp), FW'(tbl[i].e_sp));
            chk($sformatf("row%0d_ready", i), FW'(ready), FW'(tbl[i].e_rdy));
            chk($sformatf("row%0d_valid", i), FW'(pop_valid), FW'(tbl[i].e_v));
            chk($sformatf("row%0d_ovf", i), FW'(ovf), FW'(tbl[i].e_ovf));
            chk($sformatf("row%0d_unf", i), FW'(unf), FW'(tbl[i].e_unf));
            chk($sformatf("row%0d_out", i), regs_out, tbl[i].e_out);
        end

        // Reg k = k+1 frame round trip.
        do_reset();
        step(1, 0, 0, mkf(0));
        step(0, 1, 0, '0);
        step(0, 0, 0, '0);
        step(0, 0, 0, '0);
        for (int k = 0; k < N; k++)
            chk($sformatf("frame_reg%0d", k), FW'(get_reg(regs_out, k)), FW'(k + 1));

        // Back-to-back A,B,C then three pops.
        do_reset();
        step(1, 0, 0, mkf(1)); step(1, 0, 0, mkf(2)); step(1, 0, 0, mkf(3));
        for (int i = 3; i >= 1; i--) begin
            step(0, 1, 0, '0); step(0, 0, 0, '0); step(0, 0, 0, '0);
            chk($sformatf("lifo_%0d", i), regs_out, mkf(i));
        end
        chk("lifo_empty", FW'(empty), FW'(1));

        // Fill, overflow, clear, pop the 64th frame.
        do_reset();
        for (int i = 0; i < D; i++) step(1, 0, 0, mkf(i + 100));
        chk("fill_full", FW'(full), FW'(1));
        step(1, 0, 0, mkf(7));
        chk("ovf_sp", FW'(sp), FW'(D));
        chk("ovf_set", FW'(ovf), FW'(1));
        step(0, 0, 1, '0);
        chk("ovf_clr", FW'(ovf), FW'(0));
        step(1, 0, 1, '0);
        chk("ovf_wins_clr", FW'(ovf), FW'(1));
        step(0, 1, 0, '0); step(0, 0, 0, '0); step(0, 0, 0, '0);
        chk("pop_top", regs_out, mkf(D - 1 + 100));

        // Reset right after a pop is accepted.
        do_reset();
        step(1, 0, 0, mkf(9)); step(1, 0, 0, mkf(10));
        step(0, 1, 0, '0);
        do_reset();
        step(0, 0, 0, '0);
        chk("rstpop_valid", FW'(pop_valid), FW'(0));
        chk("rstpop_out", regs_out, '0);
        chk("rstpop_ready", FW'(ready), FW'(1));

        // Randomized traffic: push-heavy, pop-heavy, then balanced.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            pp     = (i < 1000) ? 75 : (i < 2000) ? 20 : 50;
            po_pct = (i < 1000) ? 20 : (i < 2000) ? 75 : 50;
            rnd = FW'({$urandom, $urandom, $urandom});
            if ($urandom_range(999) < 2)
                do_reset();
            else
                step($urandom_range(99) < pp, $urandom_range(99) < po_pct,
                     $urandom_range(99) < 5, rnd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
